rx_boxcar_decimator: RTL and testbench
======================================

// Module: rx_boxcar_decimator
// PURPOSE
// RX decimation stage between the RX I/Q source and the flocra core RX input.
// - Integrate-and-dump decimation by a runtime rate R.
// - Accepts one 32-bit I/Q sample per valid cycle.
// - Each group of R samples is summed into a 64-bit {Q,I} result.
// - Results are buffered in a FIFO and presented on an AXI-stream master with backpressure.
// PARAMETERS
// FIFO_DEPTH  16  output FIFO entries; power of two, >=2
// RATE_WIDTH  16  width of decimation rate R
// PORTS
// clk                  in   1           system clock; all logic on rising edge
// rst_n                in   1           synchronous active-low reset
// rate_axis_tdata_i    in   RATE_WIDTH  decimation rate R (0 = disabled)
// rate_axis_tvalid_i   in   1           load rate_axis_tdata_i into R
// rx_iq_axis_tdata_i   in   32          {Q[31:16], I[15:0]}, signed 16-bit each
// rx_iq_axis_tvalid_i  in   1           input sample valid; no tready, always accepted
// axis_tready_i        in   1           downstream ready
// axis_tvalid_o        out  1           FIFO head valid
// axis_tdata_o         out  64          {Qsum[63:32], Isum[31:0]}, signed
// overflow_o           out  1           sticky: a result was dropped because the FIFO was full
// fifo_count_o         out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// Clock and reset:
// - One clock (clk). Reset is synchronous, active-low (rst_n).
// - rst_n=0 at an edge clears all state:
//   R=0, sample count=0, I/Q accumulators=0, FIFO emptied, overflow_o=0.
// - Reset outputs: axis_tvalid_o=0, axis_tdata_o=0, fifo_count_o=0.
// - Reset mid-window or with the FIFO occupied discards everything. There is no partial flush.
// Rate load:
// - rate_axis_tvalid_i=1 loads R.
// - The same edge clears the count and both accumulators, restarting the window.
// - An I/Q sample valid in the same cycle is discarded.
// - R=0: input samples are ignored and accumulators stay 0.
// Accumulation (R>0, rx_iq_axis_tvalid_i=1):
// - I and Q are sign-extended to 32 bits and added to their accumulators.
// - The count increments. Cycles with tvalid=0 change nothing.
// - R<=65535 with 16-bit inputs cannot overflow 32 bits, so no saturation logic.
// Dump:
// - Occurs on the valid sample where count==R-1.
// - {acc_q+q, acc_i+i} is pushed to the FIFO.
// - Accumulators reset to 0 and count to 0 on the same edge, so there is no dead cycle.
// - R=1 dumps every sample.
// FIFO:
// - Show-ahead: axis_tdata_o is the head entry and is held stable while tvalid & !tready.
// - Pop when axis_tvalid_o & axis_tready_i.
// - Latency: with the FIFO empty, the result appears (axis_tvalid_o=1) the cycle after the dumping sample.
// - axis_tdata_o is don't-care while axis_tvalid_o=0; the bench checks only 0 at reset.
// - Full + push + pop in the same cycle: both occur, occupancy unchanged, no overflow.
// - Full + push, no pop: the new result is dropped and overflow_o is set until rst_n.
// - Empty + push: push only. A zero-depth bypass is not allowed.
// - Pointers wrap modulo FIFO_DEPTH. fifo_count_o runs 0..FIFO_DEPTH.
// TESTING
// 1. R=4; four inputs I=100, Q=-50 -> one output 64'hFFFFFF38_00000190, tvalid 1 cycle after the 4th input.
// 2. R=1; input I=-32768, Q=32767 -> 64'h00007FFF_FFFF8000 each sample; gaps in tvalid produce no output.
// 3. R=1, tready=0; 17 samples I=0..16 -> fifo_count_o=16, overflow_o=1;
//    then tready=1 drains I=0..15 in order, and overflow_o stays 1.
// 4. R=4; 2 samples, then write R=2 with a sample on the same cycle; 2 more samples (I=5,7) ->
//    a single output I=12; the earlier partial sums are discarded.
// 5. FIFO full, tready=1, dump on the same cycle -> count stays 16, overflow_o=0.
//    Separately, rst_n=0 mid-window -> tvalid=0, count=0, R=0; inputs after reset give no output until R is written.
// 6. R=65535; all inputs I=Q=-32768 -> output 64'h80008000_80008000.

Source files
------------

// File: rtl/rx_boxcar_decimator.sv
// rx_boxcar_decimator: integrate-and-dump decimator for 16-bit I/Q samples.
// Each group of R input samples becomes one 64-bit {Qsum, Isum} result.
// Results go into a show-ahead FIFO that drives an AXI-stream master.
module rx_boxcar_decimator #(
    parameter int FIFO_DEPTH = 16,
    parameter int RATE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RATE_WIDTH-1:0]         rate_axis_tdata_i,
    input  logic                          rate_axis_tvalid_i,
    input  logic [31:0]                   rx_iq_axis_tdata_i,
    input  logic                          rx_iq_axis_tvalid_i,
    input  logic                          axis_tready_i,
    output logic                          axis_tvalid_o,
    output logic [63:0]                   axis_tdata_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [RATE_WIDTH-1:0] rate_q, rate_d;
    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]           acc_i_q, acc_i_d;
    logic [31:0]           acc_q_q, acc_q_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [63:0]           fifo_mem_q [FIFO_DEPTH];

    logic [31:0] samp_i_ext, samp_q_ext;
    logic [31:0] sum_i, sum_q;
    logic        accept, dump;
    logic        fifo_empty, fifo_full, pop, wr_en;

    // Sign-extend the incoming sample and form the would-be window totals.
    always_comb begin
        samp_i_ext = {{16{rx_iq_axis_tdata_i[15]}}, rx_iq_axis_tdata_i[15:0]};
        samp_q_ext = {{16{rx_iq_axis_tdata_i[31]}}, rx_iq_axis_tdata_i[31:16]};
        sum_i      = acc_i_q + samp_i_ext;
        sum_q      = acc_q_q + samp_q_ext;
        // A rate write restarts the window, so a sample on that cycle is lost.
        accept     = rx_iq_axis_tvalid_i && !rate_axis_tvalid_i && (rate_q != '0);
        dump       = accept && (cnt_q == rate_q - RATE_WIDTH'(1));
    end

    // Rate register, sample counter and accumulators.
    always_comb begin
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        if (rate_axis_tvalid_i) begin
            rate_d  = rate_axis_tdata_i;
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (dump) begin
            // Window closes and the next one starts on the same edge.
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (accept) begin
            cnt_d   = cnt_q + RATE_WIDTH'(1);
            acc_i_d = sum_i;
            acc_q_d = sum_q;
        end
    end

    // FIFO control: a pop frees a slot for a push on the same edge even when full.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        pop        = !fifo_empty && axis_tready_i;
        wr_en      = dump && (!fifo_full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
        if (dump && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate_q     <= '0;
            cnt_q      <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            fifo_mem_q[wr_ptr_q] <= {sum_q, sum_i};
        end
    end

    // Show-ahead output: the head entry is presented whenever the FIFO is non-empty.
    always_comb begin
        axis_tvalid_o = !fifo_empty;
        axis_tdata_o  = fifo_empty ? 64'd0 : fifo_mem_q[rd_ptr_q];
        overflow_o    = overflow_q;
        fifo_count_o  = count_q;
    end

endmodule

// File: tb/tb_rx_boxcar_decimator.sv
// Testbench for rx_boxcar_decimator: directed cases plus random traffic,
// all checked against a queue-based reference model every cycle.
module tb_rx_boxcar_decimator;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rate_axis_tdata_i;
    logic        rate_axis_tvalid_i;
    logic [31:0] rx_iq_axis_tdata_i;
    logic        rx_iq_axis_tvalid_i;
    logic        axis_tready_i;
    logic        axis_tvalid_o;
    logic [63:0] axis_tdata_o;
    logic        overflow_o;
    logic [4:0]  fifo_count_o;

    int n_chk = 0;
    int n_bad = 0;

    // reference model state
    logic [63:0] mq[$];
    int          r_m, n_m, si, sq;
    bit          ovf_m;

    rx_boxcar_decimator #(.FIFO_DEPTH(DEPTH), .RATE_WIDTH(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .rate_axis_tdata_i   (rate_axis_tdata_i),
        .rate_axis_tvalid_i  (rate_axis_tvalid_i),
        .rx_iq_axis_tdata_i  (rx_iq_axis_tdata_i),
        .rx_iq_axis_tvalid_i (rx_iq_axis_tvalid_i),
        .axis_tready_i       (axis_tready_i),
        .axis_tvalid_o       (axis_tvalid_o),
        .axis_tdata_o        (axis_tdata_o),
        .overflow_o          (overflow_o),
        .fifo_count_o        (fifo_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] iq(input int q, input int i);
        logic [15:0] qq, ii;
        qq = q[15:0];
        ii = i[15:0];
        return {qq, ii};
    endfunction

    task automatic check_outputs();
        chk("tvalid", 64'(axis_tvalid_o), 64'(mq.size() > 0));
        chk("count", 64'(fifo_count_o), 64'(mq.size()));
        chk("overflow", 64'(overflow_o), 64'(ovf_m));
        if (mq.size() > 0) chk("tdata", axis_tdata_o, mq[0]);
    endtask

    task automatic model_step(input bit rst, input bit rl, input logic [15:0] rd,
                              input bit sv, input logic [31:0] sd, input bit rdy);
        bit          pop, push;
        logic [63:0] res;
        if (!rst) begin
            mq.delete();
            r_m = 0; n_m = 0; si = 0; sq = 0; ovf_m = 0;
        end else begin
            pop  = (mq.size() > 0) && rdy;
            push = 0;
            res  = '0;
            if (rl) begin
                r_m = int'(rd); n_m = 0; si = 0; sq = 0;
            end else if (sv && r_m > 0) begin
                si += int'($signed(sd[15:0]));
                sq += int'($signed(sd[31:16]));
                n_m++;
                if (n_m == r_m) begin
                    push = 1;
                    res  = {sq, si};
                    n_m = 0; si = 0; sq = 0;
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(res);
                else ovf_m = 1;
            end
        end
    endtask

    // drive one cycle, update the model at the edge, check at the following negedge
    task automatic cycle(input bit rst, input bit rl, input logic [15:0] rd,
                         input bit sv, input logic [31:0] sd, input bit rdy);
        rst_n               = rst;
        rate_axis_tvalid_i  = rl;
        rate_axis_tdata_i   = rd;
        rx_iq_axis_tvalid_i = sv;
        rx_iq_axis_tdata_i  = sd;
        axis_tready_i       = rdy;
        @(posedge clk);
        model_step(rst, rl, rd, sv, sd, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        cycle(0, 0, 16'd0, 0, 32'd0, 0);
    endtask

    task automatic set_rate(input logic [15:0] r, input bit rdy);
        cycle(1, 1, r, 0, 32'd0, rdy);
    endtask

    task automatic sample(input logic [31:0] d, input bit rdy);
        cycle(1, 0, 16'd0, 1, d, rdy);
    endtask

    task automatic idle(input bit rdy);
        cycle(1, 0, 16'd0, 0, 32'd0, rdy);
    endtask

    initial begin
        int rates[6];
        rates = '{0, 1, 2, 3, 4, 7};

        // reset state
        do_reset();
        do_reset();
        chk("rst_tdata", axis_tdata_o, 64'd0);
        chk("rst_tvalid", 64'(axis_tvalid_o), 64'd0);
        chk("rst_count", 64'(fifo_count_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);

        // 1: R=4, I=100 Q=-50
        set_rate(16'd4, 0);
        for (int k = 0; k < 4; k++) begin
            sample(iq(-50, 100), 0);
            if (k == 2) chk("t1_lat_pre", 64'(axis_tvalid_o), 64'd0);
        end
        chk("t1_lat", 64'(axis_tvalid_o), 64'd1);
        chk("t1_data", axis_tdata_o, 64'hFFFFFF38_00000190);
        idle(1);

        // 2: R=1 extremes with gaps
        set_rate(16'd1, 1);
        for (int k = 0; k < 3; k++) begin
            sample(iq(32767, -32768), 1);
            chk("t2_data", axis_tdata_o, 64'h00007FFF_FFFF8000);
            idle(1);
            idle(1);
            chk("t2_gap", 64'(axis_tvalid_o), 64'd0);
        end

        // 3: overflow then ordered drain
        set_rate(16'd1, 0);
        for (int k = 0; k <= 16; k++) sample(iq(0, k), 0);
        chk("t3_full", 64'(fifo_count_o), 64'd16);
        chk("t3_ovf", 64'(overflow_o), 64'd1);
        for (int k = 0; k < 16; k++) begin
            chk("t3_order", axis_tdata_o, {32'd0, 32'(k)});
            idle(1);
        end
        chk("t3_empty", 64'(fifo_count_o), 64'd0);
        chk("t3_sticky", 64'(overflow_o), 64'd1);

        // 5a: full + push + pop
        do_reset();
        set_rate(16'd1, 0);
        for (int k = 0; k < 16; k++) sample(iq(1, k + 100), 0);
        sample(iq(2, 7), 1);
        chk("t5_full_cnt", 64'(fifo_count_o), 64'd16);
        chk("t5_full_ovf", 64'(overflow_o), 64'd0);
        for (int k = 0; k < 16; k++) idle(1);

        // 4: rate rewrite restarts the window
        do_reset();
        set_rate(16'd4, 0);
        sample(iq(3, 9), 0);
        sample(iq(3, 9), 0);
        cycle(1, 1, 16'd2, 1, iq(3, 9), 0);
        sample(iq(0, 5), 0);
        sample(iq(0, 7), 0);
        chk("t4_count", 64'(fifo_count_o), 64'd1);
        chk("t4_data", axis_tdata_o, 64'h00000000_0000000C);
        idle(1);

        // 5b: reset mid-window, no output until R is written
        set_rate(16'd3, 1);
        sample(iq(4, 4), 1);
        do_reset();
        chk("t5_rst_valid", 64'(axis_tvalid_o), 64'd0);
        chk("t5_rst_rate", 64'(dut.rate_q), 64'd0);
        for (int k = 0; k < 5; k++) sample(iq(4, 4), 1);
        chk("t5_no_out", 64'(fifo_count_o), 64'd0);

        // 6: R=65535 with most-negative inputs
        set_rate(16'hFFFF, 1);
        for (int k = 0; k < 65535; k++) sample(iq(-32768, -32768), 1);
        chk("t6_valid", 64'(axis_tvalid_o), 64'd1);
        chk("t6_data", axis_tdata_o, 64'h80008000_80008000);
        idle(1);

        // random traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bit          rst, rl, sv, rdy;
            logic [15:0] rd;
            rst = ($urandom_range(0, 499) != 0);
            rl  = ($urandom_range(0, 39) == 0);
            rd  = 16'(rates[$urandom_range(0, 5)]);
            sv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 1) == 1);
            cycle(rst, rl, rd, sv, $urandom, rdy);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
